// File: rtl/seven_segment_pkg.sv
// Shared types and helpers for the multiplexed seven-segment scanner.
// Segment vectors are {g,f,e,d,c,b,a}, active-low.
package seven_segment_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef struct packed {
    logic [3:0] nibble;
    logic       dp;
    logic       blank;
    logic       blink;
  } digit_ctrl_t;

  localparam digit_ctrl_t DIGIT_RESET = '{
    nibble: 4'h0,
    dp:     1'b0,
    blank:  1'b1,
    blink:  1'b0
  };

  function automatic int width_of(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic [6:0] enc7(input logic [3:0] nib);
    logic [6:0] s;
    unique case (nib)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      4'hF: s = 7'b0001110;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/seven_segment_scanner_if.sv
// Display content in from the CPU side, pin-level drive out to the board.
// master = content producer, slave = scanner.
interface seven_segment_scanner_if #(
  parameter int NUM_DIGITS = 4,
  parameter int BRIGHT_W   = 4
);

  logic [4*NUM_DIGITS-1:0] digits;
  logic [NUM_DIGITS-1:0]   dp;
  logic [NUM_DIGITS-1:0]   blank;
  logic [NUM_DIGITS-1:0]   blink;
  logic                    lz_suppress;
  logic [BRIGHT_W-1:0]     brightness;
  logic [6:0]              seg;
  logic                    dp_n;
  logic [NUM_DIGITS-1:0]   an;
  logic                    frame_start;

  modport master (
    output digits, dp, blank, blink,
    output lz_suppress, brightness,
    input  seg, dp_n, an, frame_start
  );

  modport slave (
    input  digits, dp, blank, blink,
    input  lz_suppress, brightness,
    output seg, dp_n, an, frame_start
  );

endinterface

// File: rtl/seven_segment_timebase.sv
// Slot counter, digit index, PWM phase, blink phase and frame strobe.
// Next-state values are exported so the anode register lines up with cnt.
module seven_segment_timebase
  import seven_segment_pkg::*;
#(
  parameter  int TICK_CYCLES = 16,
  parameter  int NUM_DIGITS  = 4,
  parameter  int BRIGHT_W    = 2,
  parameter  int BLINK_HALF  = 160,
  localparam int CNT_W       = width_of(TICK_CYCLES),
  localparam int IDX_W       = width_of(NUM_DIGITS)
) (
  input  logic                clk,
  input  logic                reset,
  output logic [CNT_W-1:0]    cnt_nxt,
  output logic [IDX_W-1:0]    idx,
  output logic [IDX_W-1:0]    idx_nxt,
  output logic [BRIGHT_W-1:0] p_nxt,
  output logic                snap_en,
  output logic                blink_phase,
  output logic                frame_start
);

  localparam int STEP = TICK_CYCLES >> BRIGHT_W;
  localparam int SUB_W = width_of(STEP);
  localparam int BL_W = width_of(BLINK_HALF);

  localparam logic [CNT_W-1:0] CNT_MAX =
    CNT_W'(TICK_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_MAX =
    IDX_W'(NUM_DIGITS - 1);
  localparam logic [SUB_W-1:0] SUB_MAX =
    SUB_W'(STEP - 1);
  localparam logic [BL_W-1:0] BL_MAX =
    BL_W'(BLINK_HALF - 1);

  logic [CNT_W-1:0]    cnt;
  logic [SUB_W-1:0]    sub;
  logic [SUB_W-1:0]    sub_nxt;
  logic [BRIGHT_W-1:0] p;
  logic [BL_W-1:0]     bcnt;
  logic [BL_W-1:0]     bcnt_nxt;
  logic                cnt_wrap;
  logic                sub_wrap;
  logic                bl_wrap;

  // p tracks cnt / STEP with a sub-counter instead of a divider
  always_comb begin
    cnt_wrap = (cnt == CNT_MAX);
    sub_wrap = (sub == SUB_MAX);
    bl_wrap  = (bcnt == BL_MAX);
    cnt_nxt  = cnt_wrap ? '0 : cnt + 1'b1;
    idx_nxt  = idx;
    if (cnt_wrap)
      idx_nxt = (idx == IDX_MAX) ? '0 : idx + 1'b1;
    sub_nxt = (cnt_wrap || sub_wrap) ? '0 : sub + 1'b1;
    p_nxt = p;
    if (cnt_wrap)
      p_nxt = '0;
    else if (sub_wrap)
      p_nxt = p + 1'b1;
    bcnt_nxt = bl_wrap ? '0 : bcnt + 1'b1;
    snap_en  = (cnt == '0) && (idx == '0);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt         <= '0;
      idx         <= '0;
      sub         <= '0;
      p           <= '0;
      bcnt        <= '0;
      blink_phase <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      cnt         <= cnt_nxt;
      idx         <= idx_nxt;
      sub         <= sub_nxt;
      p           <= p_nxt;
      bcnt        <= bcnt_nxt;
      blink_phase <= blink_phase ^ bl_wrap;
      frame_start <= snap_en;
    end
  end

endmodule

// File: rtl/seven_segment_scanner.sv
// Multiplexed common-anode seven-segment scanner with per-frame snapshot,
// leading-zero suppression, blink and PWM brightness.
module seven_segment_scanner
  import seven_segment_pkg::*;
#(
  parameter int CLK_FREQ_HZ   = 100_000_000,
  parameter int DIGIT_RATE_HZ = 1000,
  parameter int NUM_DIGITS    = 4,
  parameter int BRIGHT_W      = 4,
  parameter int BLINK_HZ      = 2
) (
  input logic clk,
  input logic reset,
  seven_segment_scanner_if.slave bus
);

  localparam int TICK_CYCLES = CLK_FREQ_HZ / DIGIT_RATE_HZ;
  localparam int BLINK_HALF = CLK_FREQ_HZ / (2 * BLINK_HZ);
  localparam int CNT_W = width_of(TICK_CYCLES);
  localparam int IDX_W = width_of(NUM_DIGITS);

  if (TICK_CYCLES == 0 ||
      TICK_CYCLES % (1 << BRIGHT_W) != 0) begin : g_bad_tick
    $error("TICK_CYCLES must be a nonzero multiple of 2**BRIGHT_W");
  end

  if (NUM_DIGITS < 1 || NUM_DIGITS > 8) begin : g_bad_digits
    $error("NUM_DIGITS must be in 1..8");
  end

  if (BLINK_HALF < 1) begin : g_bad_blink
    $error("BLINK_HZ too high for CLK_FREQ_HZ");
  end

  logic [CNT_W-1:0]    cnt_nxt;
  logic [IDX_W-1:0]    idx;
  logic [IDX_W-1:0]    idx_nxt;
  logic [BRIGHT_W-1:0] p_nxt;
  logic                snap_en;
  logic                blink_phase;
  logic                frame_start;

  seven_segment_timebase #(
    .TICK_CYCLES (TICK_CYCLES),
    .NUM_DIGITS  (NUM_DIGITS),
    .BRIGHT_W    (BRIGHT_W),
    .BLINK_HALF  (BLINK_HALF)
  ) u_timebase (
    .clk         (clk),
    .reset       (reset),
    .cnt_nxt     (cnt_nxt),
    .idx         (idx),
    .idx_nxt     (idx_nxt),
    .p_nxt       (p_nxt),
    .snap_en     (snap_en),
    .blink_phase (blink_phase),
    .frame_start (frame_start)
  );

  digit_ctrl_t [NUM_DIGITS-1:0] live;
  digit_ctrl_t [NUM_DIGITS-1:0] snap_q;
  digit_ctrl_t [NUM_DIGITS-1:0] snap_d;
  logic                         lz_q;
  logic                         lz_d;
  logic [NUM_DIGITS-1:0]        sup;
  logic                         lead;
  digit_ctrl_t                  cur;
  logic                         dark;
  logic [6:0]                   seg_d;
  logic                         dp_n_d;
  logic [NUM_DIGITS-1:0]        an_d;
  logic [6:0]                   seg_q;
  logic                         dp_n_q;
  logic [NUM_DIGITS-1:0]        an_q;

  // The frame's first digit must already see the fresh capture
  always_comb begin
    for (int i = 0; i < NUM_DIGITS; i++) begin
      live[i] = '{
        nibble: bus.digits[4*i +: 4],
        dp:     bus.dp[i],
        blank:  bus.blank[i],
        blink:  bus.blink[i]
      };
    end
    snap_d = snap_en ? live : snap_q;
    lz_d   = snap_en ? bus.lz_suppress : lz_q;
  end

  always_comb begin
    sup  = '0;
    lead = lz_d;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      if (lead && snap_d[i].nibble == 4'h0 && !snap_d[i].dp)
        sup[i] = 1'b1;
      else
        lead = 1'b0;
    end
  end

  // seg follows idx; an follows next cnt so it is dark at cnt == 0
  always_comb begin
    cur    = snap_d[idx];
    dark   = cur.blank | sup[idx] | (cur.blink & blink_phase);
    seg_d  = dark ? SEG_BLANK : enc7(cur.nibble);
    dp_n_d = dark | ~cur.dp;
    an_d   = '1;
    if (cnt_nxt != '0 && p_nxt < bus.brightness)
      an_d[idx_nxt] = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      snap_q <= {NUM_DIGITS{DIGIT_RESET}};
      lz_q   <= 1'b0;
      seg_q  <= SEG_BLANK;
      dp_n_q <= 1'b1;
      an_q   <= '1;
    end else begin
      snap_q <= snap_d;
      lz_q   <= lz_d;
      seg_q  <= seg_d;
      dp_n_q <= dp_n_d;
      an_q   <= an_d;
    end
  end

  assign bus.seg         = seg_q;
  assign bus.dp_n        = dp_n_q;
  assign bus.an          = an_q;
  assign bus.frame_start = frame_start;

endmodule

// File: tb/tb_seven_segment_scanner.sv
// Bench: 4-digit and 3-digit scanners against a cycle-count model.
// Expected outputs are derived from elapsed cycles since reset release.
module tb_seven_segment_scanner;

  localparam int CLK_HZ = 1600;
  localparam int RATE = 100;
  localparam int ND = 4;
  localparam int BW = 2;
  localparam int BL_HZ = 5;
  localparam int TICK = CLK_HZ / RATE;
  localparam int STEP = TICK >> BW;
  localparam int FR = TICK * ND;
  localparam int FR3 = TICK * 3;
  localparam int BLH = CLK_HZ / (2 * BL_HZ);

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad = 0;
  int   n = 0;

  logic [6:0] enc [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  logic [15:0] f_dig;
  logic [3:0]  f_dp, f_blank, f_blink;
  logic        f_lz;
  logic [11:0] d3;
  logic [2:0]  dp3;
  logic [6:0]  exp_seg, exp_seg3;
  logic        exp_dpn, exp_dpn3, exp_fs, exp_fs3;
  logic [3:0]  exp_an;
  logic [2:0]  exp_an3;

  initial forever #5 clk = ~clk;

  seven_segment_scanner_if #(.NUM_DIGITS(ND), .BRIGHT_W(BW)) bus ();
  seven_segment_scanner_if #(.NUM_DIGITS(3), .BRIGHT_W(BW)) bus3 ();

  seven_segment_scanner #(
    .CLK_FREQ_HZ(CLK_HZ), .DIGIT_RATE_HZ(RATE),
    .NUM_DIGITS(ND), .BRIGHT_W(BW), .BLINK_HZ(BL_HZ)
  ) dut (.clk(clk), .reset(reset), .bus(bus));

  seven_segment_scanner #(
    .CLK_FREQ_HZ(CLK_HZ), .DIGIT_RATE_HZ(RATE),
    .NUM_DIGITS(3), .BRIGHT_W(BW), .BLINK_HZ(BL_HZ)
  ) dut3 (.clk(clk), .reset(reset), .bus(bus3));

  // One clock; then expectations for cycle n (inputs now = cycle n-1)
  task automatic advance();
    int pi, ci, ii, z, ph;
    bit dark;
    @(posedge clk);
    n++;
    @(negedge clk);
    if ((n - 1) % FR == 0) begin
      f_dig = bus.digits; f_dp = bus.dp;
      f_blank = bus.blank; f_blink = bus.blink;
      f_lz = bus.lz_suppress;
    end
    ph = ((n - 1) / BLH) % 2;
    pi = ((n - 1) / TICK) % ND;
    z = 0;
    while (z < ND - 1 && f_dig[4*(ND-1-z) +: 4] == 4'h0
           && !f_dp[ND-1-z])
      z++;
    dark = f_blank[pi] || (f_lz && pi >= ND - z)
           || (f_blink[pi] && ph == 1);
    exp_seg = dark ? 7'h7F : enc[f_dig[4*pi +: 4]];
    exp_dpn = dark || !f_dp[pi];
    ci = n % TICK;
    ii = (n / TICK) % ND;
    exp_an = 4'hF;
    if (ci != 0 && ci / STEP < bus.brightness) exp_an[ii] = 1'b0;
    exp_fs = ((n - 1) % FR) == 0;
    pi = ((n - 1) / TICK) % 3;
    ii = (n / TICK) % 3;
    exp_seg3 = enc[d3[4*pi +: 4]];
    exp_dpn3 = !dp3[pi];
    exp_an3 = 3'b111;
    if (ci != 0 && ci / STEP < bus3.brightness) exp_an3[ii] = 1'b0;
    exp_fs3 = ((n - 1) % FR3) == 0;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++;
    if (bus.an !== 4'hF) begin
      bad++; $display("FAIL reset_an got=%b exp=1111", bus.an);
    end
    total++;
    if (bus.seg !== 7'h7F) begin
      bad++; $display("FAIL reset_seg got=%h exp=7f", bus.seg);
    end
    total++;
    if (bus.dp_n !== 1'b1 || bus.frame_start !== 1'b0) begin
      bad++;
      $display("FAIL reset_dp_fs got=%b%b exp=10",
               bus.dp_n, bus.frame_start);
    end
    total++;
    if (bus3.an !== 3'b111) begin
      bad++; $display("FAIL reset_an3 got=%b exp=111", bus3.an);
    end
    reset = 1'b0;
    n = 0;
  endtask

  task automatic test_scan();
    int fs_cnt = 0;
    int on_cnt = 0;
    repeat (2 * FR) begin
      advance();
      total++;
      if (bus.an !== exp_an) begin
        bad++; $display("FAIL scan_an n=%0d got=%b exp=%b", n, bus.an, exp_an);
      end
      total++;
      if (bus.seg !== exp_seg) begin
        bad++;
        $display("FAIL scan_seg n=%0d got=%b exp=%b", n, bus.seg, exp_seg);
      end
      total++;
      if (bus.dp_n !== exp_dpn) begin
        bad++;
        $display("FAIL scan_dp n=%0d got=%b exp=%b", n, bus.dp_n, exp_dpn);
      end
      total++;
      if (bus.frame_start !== exp_fs) begin
        bad++;
        $display("FAIL scan_fs n=%0d got=%b exp=%b",
                 n, bus.frame_start, exp_fs);
      end
      if (n == 5 || n == 53) begin
        total++;
        if ((n == 5 && (bus.seg !== 7'b0001110 || bus.an !== 4'b1110)) ||
            (n == 53 && (bus.seg !== 7'b1111001 || bus.an !== 4'b0111))) begin
          bad++;
          $display("FAIL scan_fixed n=%0d got seg=%b an=%b",
                   n, bus.seg, bus.an);
        end
      end
      fs_cnt += int'(bus.frame_start);
      on_cnt += int'(bus.an != 4'hF);
    end
    total++;
    if (fs_cnt != 2) begin
      bad++; $display("FAIL scan_fs_count got=%0d exp=2", fs_cnt);
    end
    total++;
    if (on_cnt != 88) begin
      bad++; $display("FAIL scan_on_count got=%0d exp=88", on_cnt);
    end
  endtask

  task automatic test_snapshot();
    repeat (30) advance();
    bus.digits = 16'($urandom);
    bus.dp = 4'($urandom);
    repeat (2 * FR) begin
      advance();
      total++;
      if (bus.seg !== exp_seg || bus.dp_n !== exp_dpn) begin
        bad++;
        $display("FAIL snapshot n=%0d got=%b/%b exp=%b/%b",
                 n, bus.seg, bus.dp_n, exp_seg, exp_dpn);
      end
    end
  endtask

  task automatic test_lz();
    bit seen;
    int slot;
    for (int pass = 0; pass < 2; pass++) begin
      bus.digits = 16'h0050;
      bus.dp = (pass == 0) ? 4'b0000 : 4'b1000;
      bus.lz_suppress = 1'b1;
      seen = 1'b0;
      repeat (2 * FR) begin
        advance();
        if (bus.frame_start === 1'b1) seen = 1'b1;
        slot = ((n - 1) % FR) / TICK;
        total++;
        if (bus.seg !== exp_seg || bus.dp_n !== exp_dpn) begin
          bad++;
          $display("FAIL lz_model n=%0d got=%b/%b exp=%b/%b",
                   n, bus.seg, bus.dp_n, exp_seg, exp_dpn);
        end
        if (seen && slot != 1) begin
          total++;
          if ((slot == 0 && bus.seg !== 7'h40) ||
              (pass == 0 && slot >= 2 && bus.seg !== 7'h7F) ||
              (pass == 1 && slot == 2 && bus.seg !== 7'h40) ||
              (pass == 1 && slot == 3 &&
               (bus.seg !== 7'h40 || bus.dp_n !== 1'b0))) begin
            bad++;
            $display("FAIL lz_fixed pass=%0d slot=%0d got=%b/%b",
                     pass, slot, bus.seg, bus.dp_n);
          end
        end
      end
    end
    bus.lz_suppress = 1'b0;
    bus.dp = 4'b0000;
  endtask

  task automatic test_bright_blink();
    bus.brightness = 2'd0;
    repeat (FR) begin
      advance();
      total++;
      if (bus.an !== 4'hF) begin
        bad++; $display("FAIL dark_an n=%0d got=%b exp=1111", n, bus.an);
      end
    end
    bus.brightness = 2'd3;
    bus.digits = 16'h4321;
    bus.blink = 4'b0001;
    repeat (3 * BLH) begin
      advance();
      total++;
      if (bus.seg !== exp_seg || bus.an !== exp_an) begin
        bad++;
        $display("FAIL blink n=%0d got=%b/%b exp=%b/%b",
                 n, bus.seg, bus.an, exp_seg, exp_an);
      end
    end
    bus.blink = 4'b0000;
  endtask

  task automatic test_width();
    bus3.brightness = 2'd3;
    repeat (3 * FR3) begin
      advance();
      total++;
      if (bus3.an !== exp_an3 || bus3.frame_start !== exp_fs3) begin
        bad++;
        $display("FAIL w3_an n=%0d got=%b/%b exp=%b/%b",
                 n, bus3.an, bus3.frame_start, exp_an3, exp_fs3);
      end
      total++;
      if (bus3.seg !== exp_seg3 || bus3.dp_n !== exp_dpn3) begin
        bad++;
        $display("FAIL w3_seg n=%0d got=%b/%b exp=%b/%b",
                 n, bus3.seg, bus3.dp_n, exp_seg3, exp_dpn3);
      end
      if (n % TICK != 0 && n % TICK < 12) begin
        total++;
        if (bus3.an === 3'b111) begin
          bad++; $display("FAIL w3_lit n=%0d got=111 exp=one low", n);
        end
      end
    end
  endtask

  task automatic test_random();
    repeat (30) begin
      bus.digits = 16'($urandom);
      if ($urandom_range(0, 1) == 1) bus.digits[15:8] = 8'h00;
      bus.dp = 4'($urandom & $urandom);
      bus.blank = 4'($urandom & $urandom & $urandom);
      bus.blink = 4'($urandom & $urandom);
      bus.lz_suppress = 1'($urandom);
      bus.brightness = 2'($urandom);
      bus3.brightness = 2'($urandom);
      repeat ($urandom_range(5, 90)) begin
        advance();
        total++;
        if (bus.an !== exp_an || bus.frame_start !== exp_fs) begin
          bad++;
          $display("FAIL rnd_an n=%0d got=%b/%b exp=%b/%b",
                   n, bus.an, bus.frame_start, exp_an, exp_fs);
        end
        total++;
        if (bus.seg !== exp_seg || bus.dp_n !== exp_dpn) begin
          bad++;
          $display("FAIL rnd_seg n=%0d got=%b/%b exp=%b/%b",
                   n, bus.seg, bus.dp_n, exp_seg, exp_dpn);
        end
        total++;
        if (bus3.an !== exp_an3) begin
          bad++;
          $display("FAIL rnd_an3 n=%0d got=%b exp=%b", n, bus3.an, exp_an3);
        end
      end
    end
  endtask

  task automatic test_async_reset();
    bus.digits = 16'h9B3E;
    bus.blank = 4'b0000;
    bus.blink = 4'b0000;
    bus.brightness = 2'd3;
    bus3.brightness = 2'd3;
    while (n % TICK != 6) advance();
    #3 reset = 1'b1;
    #1;
    total++;
    if (bus.an !== 4'hF || bus.seg !== 7'h7F || bus.dp_n !== 1'b1) begin
      bad++;
      $display("FAIL async_rst got an=%b seg=%h dp=%b exp 1111/7f/1",
               bus.an, bus.seg, bus.dp_n);
    end
    total++;
    if (bus3.an !== 3'b111 || bus.frame_start !== 1'b0) begin
      bad++;
      $display("FAIL async_rst3 got an3=%b fs=%b exp 111/0",
               bus3.an, bus.frame_start);
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    n = 0;
    repeat (FR + 10) begin
      advance();
      total++;
      if (bus.an !== exp_an || bus.seg !== exp_seg
          || bus.frame_start !== exp_fs) begin
        bad++;
        $display("FAIL resume n=%0d got=%b/%b/%b exp=%b/%b/%b",
                 n, bus.an, bus.seg, bus.frame_start,
                 exp_an, exp_seg, exp_fs);
      end
    end
  endtask

  initial begin
    d3 = 12'h5C7;
    dp3 = 3'b010;
    bus.digits = 16'h1A2F;
    bus.dp = 4'b0000;
    bus.blank = 4'b0000;
    bus.blink = 4'b0000;
    bus.lz_suppress = 1'b0;
    bus.brightness = 2'd3;
    bus3.digits = d3;
    bus3.dp = dp3;
    bus3.blank = 3'b000;
    bus3.blink = 3'b000;
    bus3.lz_suppress = 1'b0;
    bus3.brightness = 2'd3;
    test_reset();
    test_scan();
    test_snapshot();
    test_lz();
    test_bright_blink();
    test_width();
    test_random();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
